// File: rtl/idu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idu_pkg
// Purpose  : Shared types for the pointer increment/decrement unit.
// Revision : 1.0 - initial release
// ============================================================================
package idu_pkg;

    typedef enum logic [2:0] {
        OP_PASS      = 3'd0,
        OP_INC       = 3'd1,
        OP_DEC       = 3'd2,
        OP_LOAD      = 3'd3,
        OP_BURST_INC = 3'd4,
        OP_BURST_DEC = 3'd5
    } idu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } idu_state_e;

    // Select width that never collapses to zero bits for a single pointer.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idu_step.sv
`default_nettype none
// ============================================================================
// Module   : idu_step
// Purpose  : Combinational +/-1 stepper with modulo-2^WIDTH wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module idu_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    output logic [WIDTH-1:0] result,
    output logic             wrap
);

    assign result = up ? (value + WIDTH'(1)) : (value - WIDTH'(1));
    assign wrap   = up ? (&value) : ~(|value);

endmodule
`default_nettype wire

// File: rtl/idu_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : idu_ptr_unit
// Purpose  : Registered pointer file with post-update INC/DEC/LOAD and bursts.
// Revision : 1.0 - initial release
// ============================================================================
module idu_ptr_unit
    import idu_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NUM_PTRS  = 4,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEL_W     = sel_w(NUM_PTRS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  idu_op_e          req_op,
    input  logic [SEL_W-1:0] req_sel,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CNT_W-1:0] req_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_addr,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_wrap,
    output logic             out_last,
    input  logic [SEL_W-1:0] peek_sel,
    output logic [WIDTH-1:0] peek_data
);

    logic [WIDTH-1:0] r_ptr [NUM_PTRS];
    idu_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
    logic [SEL_W-1:0] r_burst_sel;
    logic             r_burst_up;

    logic             r_out_valid, r_out_wrap, r_out_last;
    logic [WIDTH-1:0] r_out_addr;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_adv, w_accept, w_sel_ok, w_step_up, w_step_wrap;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_cur, w_step_val, w_peek;
    logic             w_beat, w_beat_wrap, w_beat_last, w_ptr_we;
    logic [WIDTH-1:0] w_beat_addr, w_ptr_wdata;

    assign w_adv     = !r_out_valid || out_ready;
    assign req_ready = (r_state == ST_IDLE) && w_adv;
    assign w_accept  = req_valid && req_ready;
    assign w_sel_ok  = int'(req_sel) < NUM_PTRS;
    assign w_idx     = (r_state == ST_BURST) ? r_burst_sel : req_sel;
    assign w_step_up = (r_state == ST_BURST) ? r_burst_up
                                             : (req_op == OP_INC || req_op == OP_BURST_INC);

    // Out-of-range selects read as zero rather than indexing past the file.
    always_comb begin
        w_cur  = '0;
        w_peek = '0;
        for (int i = 0; i < NUM_PTRS; i++) begin
            if (w_idx == SEL_W'(i))    w_cur  = r_ptr[i];
            if (peek_sel == SEL_W'(i)) w_peek = r_ptr[i];
        end
    end
    assign peek_data = w_peek;

    idu_step #(.WIDTH(WIDTH)) u_step (
        .value  (w_cur),
        .up     (w_step_up),
        .result (w_step_val),
        .wrap   (w_step_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_sel_ok && (req_op == OP_BURST_INC || req_op == OP_BURST_DEC)
                    && (req_count > CNT_W'(1)))
                    w_state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (w_adv && (r_remaining == CNT_W'(1))) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_beat          = 1'b0;
        w_beat_addr     = w_cur;
        w_beat_wrap     = 1'b0;
        w_beat_last     = 1'b1;
        w_ptr_we        = 1'b0;
        w_ptr_wdata     = w_step_val;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_beat = 1'b1;
                    if (w_sel_ok) begin
                        case (req_op)
                            OP_INC, OP_DEC: begin
                                w_ptr_we    = 1'b1;
                                w_beat_wrap = w_step_wrap;
                            end
                            OP_LOAD: begin
                                w_beat_addr = req_data;
                                w_ptr_wdata = req_data;
                                w_ptr_we    = 1'b1;
                            end
                            OP_BURST_INC, OP_BURST_DEC: begin
                                // A zero-length burst degenerates to a PASS beat.
                                if (req_count != '0) begin
                                    w_ptr_we    = 1'b1;
                                    w_beat_wrap = w_step_wrap;
                                end
                                if (req_count > CNT_W'(1)) begin
                                    w_beat_last     = 1'b0;
                                    w_remaining_nxt = req_count - CNT_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_BURST: begin
                if (w_adv) begin
                    w_beat          = 1'b1;
                    w_ptr_we        = 1'b1;
                    w_beat_wrap     = w_step_wrap;
                    w_beat_last     = (r_remaining == CNT_W'(1));
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PTRS; i++) r_ptr[i] <= RESET_VAL;
            r_remaining <= '0;
            r_burst_sel <= '0;
            r_burst_up  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_sel   <= '0;
            r_out_wrap  <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                if (w_ptr_we && (w_idx == SEL_W'(i))) r_ptr[i] <= w_ptr_wdata;
            end
            r_remaining <= w_remaining_nxt;
            if (w_accept) begin
                r_burst_sel <= req_sel;
                r_burst_up  <= (req_op == OP_BURST_INC);
            end
            if (w_adv) begin
                r_out_valid <= w_beat;
                if (w_beat) begin
                    r_out_addr <= w_beat_addr;
                    r_out_sel  <= w_idx;
                    r_out_wrap <= w_beat_wrap;
                    r_out_last <= w_beat_last;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_sel   = r_out_sel;
    assign out_wrap  = r_out_wrap;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_idu_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_idu_ptr_unit
// Purpose  : Directed scoreboard bench for idu_ptr_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idu_ptr_unit;
    import idu_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  sel;
        logic        wrap;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    idu_op_e     req_op = OP_PASS;
    logic [1:0]  req_sel = '0;
    logic [15:0] req_data = '0;
    logic [7:0]  req_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_addr;
    logic [1:0]  out_sel;
    logic        out_wrap;
    logic        out_last;
    logic [1:0]  peek_sel = '0;
    logic [15:0] peek_data;

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    beat_t       q[$];
    logic [15:0] m_ptr [4];
    beat_t       obs, exp_b;

    idu_ptr_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_sel(req_sel), .req_data(req_data), .req_count(req_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_sel(out_sel), .out_wrap(out_wrap), .out_last(out_last),
        .peek_sel(peek_sel), .peek_data(peek_data)
    );

    always #5 clk = ~clk;

    // Every displayed beat is compared; it is popped only when consumed,
    // so a stalled beat is re-checked for stability each cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            obs = '{out_addr, out_sel, out_wrap, out_last};
            if (q.size() == 0) begin
                errors++;
                $error("FAIL beat unexpected addr=%h sel=%0d wrap=%b last=%b required=none",
                       out_addr, out_sel, out_wrap, out_last);
            end else begin
                exp_b = q[0];
                assert (obs === exp_b) else begin
                    errors++;
                    $error("FAIL beat addr=%h sel=%0d wrap=%b last=%b required addr=%h sel=%0d wrap=%b last=%b",
                           obs.addr, obs.sel, obs.wrap, obs.last,
                           exp_b.addr, exp_b.sel, exp_b.wrap, exp_b.last);
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic peek_chk(input int s);
        peek_sel = 2'(s);
        #1;
        chk($sformatf("peek%0d", s), 32'(peek_data), 32'(m_ptr[s]));
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout observed=stuck expected=progress", tag);
    endtask

    // Reference model: appends the beats a request must produce.
    task automatic model(input idu_op_e op, input int s, input logic [15:0] d, input int cnt);
        bit up;
        case (op)
            OP_INC: begin
                q.push_back('{m_ptr[s], 2'(s), m_ptr[s] == 16'hFFFF, 1'b1});
                m_ptr[s] = m_ptr[s] + 16'd1;
            end
            OP_DEC: begin
                q.push_back('{m_ptr[s], 2'(s), m_ptr[s] == 16'h0000, 1'b1});
                m_ptr[s] = m_ptr[s] - 16'd1;
            end
            OP_LOAD: begin
                q.push_back('{d, 2'(s), 1'b0, 1'b1});
                m_ptr[s] = d;
            end
            OP_BURST_INC, OP_BURST_DEC: begin
                up = (op == OP_BURST_INC);
                if (cnt == 0) q.push_back('{m_ptr[s], 2'(s), 1'b0, 1'b1});
                for (int i = 0; i < cnt; i++) begin
                    q.push_back('{m_ptr[s], 2'(s),
                                  up ? (m_ptr[s] == 16'hFFFF) : (m_ptr[s] == 16'h0000),
                                  i == cnt - 1});
                    m_ptr[s] = up ? m_ptr[s] + 16'd1 : m_ptr[s] - 16'd1;
                end
            end
            default: q.push_back('{m_ptr[s], 2'(s), 1'b0, 1'b1});
        endcase
    endtask

    task automatic do_req(input idu_op_e op, input int s, input logic [15:0] d, input int cnt);
        int n = 0;
        bit accepted = 0;
        req_op = op; req_sel = 2'(s); req_data = d; req_count = 8'(cnt);
        req_valid = 1'b1;
        while (!accepted) begin
            @(negedge clk); #1;
            if (req_ready) begin
                accepted = 1;
                model(op, s, d, cnt);
            end else if (++n > 1000) begin
                timeout("req_accept");
                accepted = 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit busy_chk, input bit stall);
        int n = 0;
        bit done = 0;
        while (!done) begin
            if (stall) out_ready = (n % 3 == 0);
            @(negedge clk); #1;
            if (q.size() == 0 && req_ready) begin
                done = 1;
            end else begin
                if (busy_chk && q.size() > 1) chk("ready_in_burst", 32'(req_ready), 32'd0);
                if (++n > 2000) begin
                    timeout("drain");
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < 4; i++) m_ptr[i] = 16'h0000;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_wrap", 32'(out_wrap), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) peek_chk(i);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back post-update ops on one pointer.
        do_req(OP_LOAD, 2, 16'h0011, 0);
        do_req(OP_INC,  2, 16'h0000, 0);
        do_req(OP_DEC,  2, 16'h0000, 0);
        wait_idle(0, 0);
        peek_chk(2);

        do_req(OP_LOAD, 0, 16'hFFFF, 0);
        do_req(OP_INC,  0, 16'h0000, 0);
        wait_idle(0, 0);
        peek_chk(0);
        do_req(OP_DEC,  0, 16'h0000, 0);
        wait_idle(0, 0);
        peek_chk(0);

        do_req(OP_LOAD, 1, 16'hC000, 0);
        do_req(OP_BURST_INC, 1, 16'h0000, 160);
        wait_idle(1, 0);
        peek_chk(1);

        do_req(OP_LOAD, 3, 16'h0002, 0);
        wait_idle(0, 0);
        do_req(OP_BURST_DEC, 3, 16'h0000, 4);
        wait_idle(1, 1);
        peek_chk(3);

        // Reset in the middle of a long burst.
        base = pops;
        do_req(OP_BURST_INC, 1, 16'h0000, 100);
        n = 0;
        while (pops < base + 10 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (pops < base + 10) timeout("burst_beats");
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        q.delete();
        for (int i = 0; i < 4; i++) m_ptr[i] = 16'h0000;
        for (int i = 0; i < 4; i++) peek_chk(i);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_no_beat", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Zero-count burst is a single PASS beat.
        do_req(OP_LOAD, 2, 16'h1234, 0);
        do_req(OP_BURST_INC, 2, 16'h0000, 0);
        wait_idle(0, 0);
        peek_chk(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
